// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: register map, CTRL bit fields,
// mode encodings and the sequencer FSM state type.
package led_seq_pkg;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_MANUAL = 2'd1;
   localparam logic [1:0] ADDR_PERIOD = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam int CTRL_MODE_LSB = 0;
   localparam int CTRL_EN_BIT   = 2;
   localparam int CTRL_OVR_BIT  = 3;

   typedef enum logic [1:0] {
      MODE_MANUAL = 2'd0,
      MODE_SHIFT  = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_BLINK  = 2'd3
   } mode_e;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_MANUAL,
      ST_SHIFT,
      ST_BOUNCE_L,
      ST_BOUNCE_R,
      ST_BLINK_ON,
      ST_BLINK_OFF
   } state_e;

   // Mode a running state belongs to; OFF has no mode and is handled separately.
   function automatic mode_e state_mode(input state_e s);
      case (s)
         ST_SHIFT:                  return MODE_SHIFT;
         ST_BOUNCE_L, ST_BOUNCE_R:  return MODE_BOUNCE;
         ST_BLINK_ON, ST_BLINK_OFF: return MODE_BLINK;
         default:                   return MODE_MANUAL;
      endcase
   endfunction

   function automatic state_e entry_state(input mode_e m);
      case (m)
         MODE_SHIFT:  return ST_SHIFT;
         MODE_BOUNCE: return ST_BOUNCE_L;
         MODE_BLINK:  return ST_BLINK_ON;
         default:     return ST_MANUAL;
      endcase
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus debouncer for the slide switches: the output
// follows the synchronised vector only after it has held steady long enough.
module sw_debounce #(
   parameter int DEBOUNCE_CYC = 500000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] sw_in,
   output logic [3:0] sw_db
);

   localparam int          CW       = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

   logic [3:0]    sync1, sync2, cand;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
         cand  <= '0;
         cnt   <= '0;
         sw_db <= '0;
      end else begin
         sync1 <= sw_in;
         sync2 <= sync1;
         // cand tracks the last synchronised value; any change restarts the count
         if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= '0;
         end else if (cand != sw_db) begin
            if (cnt == CNT_LAST) begin
               sw_db <= cand;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/led_seq_ctrl.sv
// Avalon-MM controlled LED pattern sequencer: register file, tick generator
// and the pattern FSM driving eight LEDs.
module led_seq_ctrl
   import led_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 500000,
   parameter int PERIOD_RST   = 5000000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  avs_address,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   output logic [31:0] avs_readdata,
   input  logic [3:0]  sw_in,
   output logic [7:0]  led_out
);

   logic [3:0]  ctrl_q;
   logic [7:0]  manual_q;
   logic [23:0] period_q;
   logic [23:0] tick_cnt;
   logic [3:0]  sw_db;
   mode_e       eff_mode, mode_q;
   logic        en, en_q;
   state_e      state, state_d;
   logic [7:0]  led_d;
   logic [31:0] rd_mux;
   logic        wr_ctrl, wr_manual, wr_period;
   logic [23:0] reload_src, reload_val;
   logic        reload, tick;
   logic        unused_wdata;

   sw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_sw_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .sw_in   (sw_in),
      .sw_db   (sw_db)
   );

   assign wr_ctrl      = avs_write && (avs_address == ADDR_CTRL);
   assign wr_manual    = avs_write && (avs_address == ADDR_MANUAL);
   assign wr_period    = avs_write && (avs_address == ADDR_PERIOD);
   assign unused_wdata = ^avs_writedata[31:24];

   assign en       = ctrl_q[CTRL_EN_BIT];
   assign eff_mode = mode_e'(ctrl_q[CTRL_OVR_BIT] ? sw_db[1:0] : ctrl_q[CTRL_MODE_LSB +: 2]);

   // ---------------- register file ----------------
   always_comb begin
      rd_mux = '0;
      case (avs_address)
         ADDR_CTRL:   rd_mux[3:0]  = ctrl_q;
         ADDR_MANUAL: rd_mux[7:0]  = manual_q;
         ADDR_PERIOD: rd_mux[23:0] = period_q;
         default:     rd_mux[13:0] = {eff_mode, led_out, sw_db};
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q       <= '0;
         manual_q     <= '0;
         period_q     <= 24'(PERIOD_RST);
         avs_readdata <= '0;
      end else begin
         if (wr_ctrl)   ctrl_q   <= avs_writedata[3:0];
         if (wr_manual) manual_q <= avs_writedata[7:0];
         if (wr_period) period_q <= avs_writedata[23:0];
         // mux sees the registers before this edge's write lands
         if (avs_read)  avs_readdata <= rd_mux;
      end
   end

   // ---------------- tick generator ----------------
   // A PERIOD write reloads from the incoming value, not the stale register.
   always_comb begin
      reload_src = wr_period ? avs_writedata[23:0] : period_q;
      reload_val = (reload_src == 24'd0) ? 24'd0 : reload_src - 24'd1;
   end

   assign reload = wr_period || (eff_mode != mode_q) || (en && !en_q);
   assign tick   = (tick_cnt == 24'd0) && !reload;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt <= 24'(PERIOD_RST - 1);
         mode_q   <= MODE_MANUAL;
         en_q     <= 1'b0;
      end else begin
         mode_q <= eff_mode;
         en_q   <= en;
         if (reload || tick_cnt == 24'd0) tick_cnt <= reload_val;
         else                             tick_cnt <= tick_cnt - 24'd1;
      end
   end

   // ---------------- pattern FSM ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_OFF;
         led_out <= '0;
      end else begin
         state   <= state_d;
         led_out <= led_d;
      end
   end

   always_comb begin
      state_d = state;
      led_d   = led_out;
      if (!en) begin
         state_d = ST_OFF;
         led_d   = '0;
      end else if (state == ST_OFF || state_mode(state) != eff_mode) begin
         // mode entry ignores any tick landing on the same cycle
         state_d = entry_state(eff_mode);
         case (eff_mode)
            MODE_SHIFT, MODE_BOUNCE: led_d = 8'h01;
            default:                 led_d = manual_q;
         endcase
      end else begin
         case (state)
            ST_MANUAL: led_d = manual_q;
            ST_SHIFT:  if (tick) led_d = {led_out[6:0], led_out[7]};
            ST_BOUNCE_L: if (tick) begin
               led_d = {led_out[6:0], 1'b0};
               if (led_out[6]) state_d = ST_BOUNCE_R;
            end
            ST_BOUNCE_R: if (tick) begin
               led_d = {1'b0, led_out[7:1]};
               if (led_out[1]) state_d = ST_BOUNCE_L;
            end
            ST_BLINK_ON: if (tick) begin
               state_d = ST_BLINK_OFF;
               led_d   = '0;
            end
            ST_BLINK_OFF: if (tick) begin
               state_d = ST_BLINK_ON;
               led_d   = manual_q;
            end
            default: begin
               state_d = ST_OFF;
               led_d   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl: expected read data and LED sequences are
// queued as stimulus is applied and compared as the DUT produces them.
module tb_led_seq_ctrl;

   localparam int DEB  = 4;
   localparam int PRST = 20;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  avs_address;
   logic        avs_read, avs_write;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;
   logic [3:0]  sw_in;
   logic [7:0]  led_out;

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] rd_q[$];
   logic [7:0]  led_q[$];

   led_seq_ctrl #(.DEBOUNCE_CYC(DEB), .PERIOD_RST(PRST)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .avs_address   (avs_address),
      .avs_read      (avs_read),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_readdata  (avs_readdata),
      .sw_in         (sw_in),
      .led_out       (led_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
      end
   endtask

   task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      avs_address = a; avs_writedata = d; avs_write = 1'b1;
      @(negedge clk);
      avs_write = 1'b0;
   endtask

   task automatic avs_rd(input string tag, input logic [1:0] a, input logic [31:0] mask,
                         input logic [31:0] exp);
      @(negedge clk);
      avs_address = a; avs_read = 1'b1;
      rd_q.push_back(exp);
      @(negedge clk);
      avs_read = 1'b0;
      chk(tag, avs_readdata & mask, rd_q.pop_front());
   endtask

   // same-cycle read and write to one register
   task automatic avs_rw(input string tag, input logic [1:0] a, input logic [31:0] d,
                         input logic [31:0] exp);
      @(negedge clk);
      avs_address = a; avs_writedata = d; avs_read = 1'b1; avs_write = 1'b1;
      rd_q.push_back(exp);
      @(negedge clk);
      avs_read = 1'b0; avs_write = 1'b0;
      chk(tag, avs_readdata, rd_q.pop_front());
   endtask

   task automatic push_led(input logic [7:0] v, input int n);
      for (int i = 0; i < n; i++) led_q.push_back(v);
   endtask

   task automatic run_led(input string tag);
      while (led_q.size() > 0) begin
         @(negedge clk);
         chk(tag, {24'd0, led_out}, {24'd0, led_q.pop_front()});
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      reset_n = 1'b0; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
      avs_writedata = '0; sw_in = '0;
      #1;
      chk("rst_led", {24'd0, led_out}, 32'h0);
      chk("rst_rdata", avs_readdata, 32'h0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      avs_rd("rst_ctrl",   2'd0, 32'hFFFF_FFFF, 32'h0);
      avs_rd("rst_manual", 2'd1, 32'hFFFF_FFFF, 32'h0);
      avs_rd("rst_period", 2'd2, 32'hFFFF_FFFF, PRST);
      avs_rd("rst_status", 2'd3, 32'hFFFF_FFFF, 32'h0);

      // register access, unused bits, STATUS write ignored, read-before-write
      avs_wr(2'd2, 32'hFF00_0003);
      avs_rd("period_rb", 2'd2, 32'hFFFF_FFFF, 32'h0000_0003);
      avs_wr(2'd1, 32'h1234_5678);
      avs_rd("manual_rb", 2'd1, 32'hFFFF_FFFF, 32'h78);
      avs_wr(2'd3, 32'hFFFF_FFFF);
      avs_rd("status_ro", 2'd3, 32'hFFFF_FFFF, 32'h0);
      avs_rw("rw_old", 2'd1, 32'h0000_00A5, 32'h78);
      avs_rd("rw_new", 2'd1, 32'hFFFF_FFFF, 32'hA5);

      // SHIFT
      avs_wr(2'd0, 32'h5);
      chk("shift_pre", {24'd0, led_out}, 32'h0);
      for (int i = 0; i < 9; i++) push_led(8'(1 << (i % 8)), 3);
      run_led("shift");
      avs_rd("ctrl_rb", 2'd0, 32'hFFFF_FFFF, 32'h5);

      // BOUNCE, entered directly from SHIFT
      avs_wr(2'd0, 32'h6);
      for (int i = 0; i < 8; i++) push_led(8'(1 << i), 3);
      for (int i = 6; i >= 0; i--) push_led(8'(1 << i), 3);
      push_led(8'h02, 3);
      run_led("bounce");

      // BLINK with MANUAL=0xA5, then 0x3C written during an off phase
      avs_wr(2'd0, 32'h7);
      push_led(8'hA5, 3); push_led(8'h00, 3); push_led(8'hA5, 3);
      run_led("blink");
      avs_wr(2'd1, 32'h3C);
      push_led(8'h00, 1); push_led(8'h3C, 3); push_led(8'h00, 3);
      run_led("blink_upd");

      // MANUAL mode and its one-cycle write latency
      avs_wr(2'd0, 32'h4);
      @(negedge clk);
      chk("manual_entry", {24'd0, led_out}, 32'h3C);
      avs_wr(2'd1, 32'h5A);
      chk("manual_lat0", {24'd0, led_out}, 32'h3C);
      @(negedge clk);
      chk("manual_lat1", {24'd0, led_out}, 32'h5A);

      // switch override: glitch rejected, held value accepted
      avs_wr(2'd0, 32'hC);
      @(negedge clk); sw_in = 4'h1;
      repeat (2) @(negedge clk); sw_in = 4'h0;
      repeat (12) @(negedge clk);
      avs_rd("sw_glitch", 2'd3, 32'hFFFF_FFFF, 32'h5A0);
      @(negedge clk); sw_in = 4'h1;
      k = 0;
      while (led_out == 8'h5A && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("sw_wait", {31'd0, k < 40}, 32'h1);
      chk("sw_shift", {24'd0, led_out}, 32'h01);
      avs_rd("sw_status", 2'd3, 32'h0000_300F, 32'h0000_1001);

      // PERIOD=0: rotate every cycle, then disable
      avs_wr(2'd0, 32'h4);
      avs_wr(2'd2, 32'h0);
      avs_wr(2'd0, 32'h5);
      for (int i = 0; i < 9; i++) push_led(8'(1 << (i % 8)), 1);
      run_led("fast_shift");
      avs_wr(2'd0, 32'h1);
      @(negedge clk);
      chk("disable", {24'd0, led_out}, 32'h0);

      // reset in the middle of BOUNCE
      sw_in = 4'h0;
      avs_wr(2'd2, 32'h3);
      avs_wr(2'd0, 32'h6);
      repeat (10) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_led", {24'd0, led_out}, 32'h0);
      chk("mid_rst_rdata", avs_readdata, 32'h0);
      @(negedge clk); reset_n = 1'b1;
      avs_rd("post_status", 2'd3, 32'hFFFF_FFFF, 32'h0);
      avs_rd("post_period", 2'd2, 32'hFFFF_FFFF, PRST);
      avs_rd("post_ctrl",   2'd0, 32'hFFFF_FFFF, 32'h0);
      chk("post_led", {24'd0, led_out}, 32'h0);
      avs_wr(2'd0, 32'h6);
      push_led(8'h01, 5);
      run_led("restart");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 500000, meaning the number of consecutive stable cycles before a switch change is accepted (10 ms at 50 MHz).
REQ-002 SHALL have parameter PERIOD_RST, default 5000000, meaning the reset value of the PERIOD register (100 ms tick at 50 MHz).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port avs_address, input, 2, Avalon-MM word address.
REQ-006 SHALL have ports avs_read and avs_write, input, 1 each, Avalon-MM strobes.
REQ-007 SHALL have port avs_writedata, input, 32, write data.
REQ-008 SHALL have port avs_readdata, output, 32, read data with fixed read latency 1 and no waitrequest.
REQ-009 SHALL have port sw_in, input, 4, asynchronous slide-switch inputs.
REQ-010 SHALL have port led_out, output, 8, registered LED drive, 1 = on.

Function
REQ-011 SHALL decode register map: 0 CTRL (RW: [1:0] mode, [2] enable, [3] sw_override); 1 MANUAL (RW: [7:0] pattern); 2 PERIOD (RW: [23:0] cycles per tick); 3 STATUS (RO: [3:0] debounced sw, [11:4] led_out, [13:12] effective mode); unused bits read 0.
REQ-012 SHALL ignore writes to STATUS and return avs_readdata one cycle after avs_read; a same-cycle read and write to one register SHALL return the pre-write value.
REQ-013 SHALL synchronise sw_in through 2 flops and update sw_db only after the synchronised vector is unchanged for DEBOUNCE_CYC consecutive cycles; any change restarts the count.
REQ-014 SHALL take effective mode from sw_db[1:0] when sw_override=1, else CTRL[1:0]; mode encoding 0 MANUAL, 1 SHIFT, 2 BOUNCE, 3 BLINK.
REQ-015 SHALL generate a 1-cycle tick every max(PERIOD,1) cycles from a down-counter; PERIOD=0 SHALL behave as 1 (tick every cycle).
REQ-016 SHALL reload the tick counter on any PERIOD write, effective-mode change or enable 0->1, with the first tick following a full period.
REQ-017 SHALL implement FSM states OFF, MANUAL, SHIFT, BOUNCE_L, BOUNCE_R, BLINK_ON, BLINK_OFF.
REQ-018 SHALL hold OFF with led_out=0x00 while enable=0, from any state, on the next clock.
REQ-019 MANUAL: led_out SHALL follow the MANUAL register with 1-cycle latency after a write; no tick dependency.
REQ-020 SHIFT: SHALL load 0x01 on entry; each tick rotates left; 0x80 wraps to 0x01.
REQ-021 BOUNCE: SHALL load 0x01 in BOUNCE_L on entry; each tick shifts left until 0x80, then BOUNCE_R shifts right until 0x01, then BOUNCE_L; endpoints each shown for exactly one tick.
REQ-022 BLINK: SHALL enter BLINK_ON showing MANUAL; each tick toggles BLINK_ON/BLINK_OFF (0x00); MANUAL writes take effect at the next BLINK_ON display.
REQ-023 SHALL, on effective-mode change while enabled, enter the new mode's entry state on the next clock regardless of tick; a tick coincident with the change SHALL be discarded.

Reset
REQ-024 SHALL on reset_n=0 asynchronously clear CTRL, MANUAL, sw_db, sync flops, debounce count, FSM (OFF), led_out=0x00, avs_readdata=0, and set PERIOD=PERIOD_RST and tick counter to PERIOD_RST-1.
REQ-025 SHALL restart all sequences from entry values after reset deassertion mid-pattern; no state survives reset.

Structure
REQ-026 SHALL place register address constants, CTRL bit positions, mode encodings and the FSM state typedef in shared package led_seq_pkg.
REQ-027 SHALL implement the synchroniser/debouncer as sub-module sw_debounce (parameter DEBOUNCE_CYC, 4-bit in, 4-bit out); everything else in led_seq_ctrl.

Verification (bench uses DEBOUNCE_CYC=4, PERIOD written to 3)
REQ-028 SHALL cover: write CTRL=0x5 (SHIFT, enable) -> led_out 0x01,0x02,...,0x80,0x01 changing every 3 cycles.
REQ-029 SHALL cover: CTRL=0x6 (BOUNCE) -> 0x01..0x80 then 0x40..0x01 then 0x02, each value held 3 cycles.
REQ-030 SHALL cover: MANUAL=0xA5, CTRL=0x7 (BLINK) -> 0xA5/0x00 alternating every 3 cycles; MANUAL=0x3C during BLINK_OFF -> next on-phase 0x3C.
REQ-031 SHALL cover: CTRL=0xC, sw_in glitch 0x1 for 2 cycles -> STATUS[3:0] stays 0; sw_in=0x1 held >=6 cycles -> STATUS[3:0]=0x1, led_out enters SHIFT at 0x01.
REQ-032 SHALL cover: PERIOD=0 in SHIFT -> led_out rotates every cycle; enable cleared -> led_out 0x00 next cycle.
REQ-033 SHALL cover: reset_n pulsed low mid-BOUNCE -> led_out 0x00 immediately, STATUS reads 0, PERIOD reads PERIOD_RST.
